// File: rtl/keccak_chi_dom_stream.sv
// DOM-masked Keccak chi (+ optional iota) over ROWS 5-bit rows, 2-stage valid/ready pipeline.
// Optional iota injection is enabled by defining KECCAK_CHI_IOTA_EN.
module keccak_chi_dom_stream #(
  parameter int unsigned SHARES    = 2,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned LESS_RAND = 0
) (
  input  logic                                  ClkxCI,
  input  logic                                  RstxRBI,
  input  logic                                  FlushxSI,
  input  logic                                  InValidxSI,
  output logic                                  InReadyxSO,
  input  logic [SHARES*ROWS*5-1:0]              InputxDI,
  input  logic                                  ZValidxSI,
  input  logic [ROWS*5*SHARES*(SHARES-1)/2-1:0] ZxDI,
  input  logic                                  RCxDI,
  output logic                                  OutValidxSO,
  input  logic                                  OutReadyxSI,
  output logic [SHARES*ROWS*5-1:0]              OutputxDO,
  output logic [1:0]                            InFlightxDO
);

  localparam int unsigned LANE      = ROWS * 5;
  localparam int unsigned DW        = SHARES * LANE;
  localparam int unsigned NPAIR     = SHARES * (SHARES - 1) / 2;
  localparam int unsigned DOMW      = SHARES * SHARES * LANE;
  localparam int unsigned LAST_PAIR = NPAIR - 1;

  logic            v1_q, v2_q, v1_d, v2_d;
  logic [1:0]      inflight_q, inflight_d;
  logic [DOMW-1:0] dom_q, dom_d;
  logic [DW-1:0]   out_q, out_d;
  logic            adv1, adv2, accept, load1, load2;
  logic            rc_bit;
  logic            z_unused;

  // With reduced randomness the last pair's Z bits are never consumed.
  assign z_unused = ^ZxDI;

`ifdef KECCAK_CHI_IOTA_EN
  assign rc_bit = RCxDI;
`else
  logic rc_unused;
  assign rc_unused = RCxDI;
  assign rc_bit    = 1'b0;
`endif

  // Handshake: stage 2 frees when empty or drained, stage 1 when it can move down.
  assign adv2       = ~v2_q | OutReadyxSI;
  assign adv1       = v1_q & adv2;
  assign InReadyxSO = ~v1_q | adv2;
  assign accept     = InValidxSI & ZValidxSI & InReadyxSO;
  assign load1      = accept & ~FlushxSI;
  assign load2      = adv1 & ~FlushxSI;

  always_comb begin : p_next
    v1_d = v1_q;
    v2_d = v2_q;
    if (FlushxSI) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv2) v2_d = v1_q;
      if (accept) v1_d = 1'b1;
      else if (adv1) v1_d = 1'b0;
    end
    inflight_d = 2'(v1_d) + 2'(v2_d);
  end

  // Stage-1 DOM terms: FF(i,i) inner domain term, FF(i,j) cross-domain product plus refresh.
  for (genvar i = 0; i < SHARES; i++) begin : g_si
    for (genvar j = 0; j < SHARES; j++) begin : g_sj
      for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar x = 0; x < 5; x++) begin : g_bit
          localparam int unsigned B0  = (i * ROWS + r) * 5 + x;
          localparam int unsigned B1  = (i * ROWS + r) * 5 + (x + 1) % 5;
          localparam int unsigned B2  = (i * ROWS + r) * 5 + (x + 2) % 5;
          localparam int unsigned JB2 = (j * ROWS + r) * 5 + (x + 2) % 5;
          localparam int unsigned D   = ((i * SHARES + j) * ROWS + r) * 5 + x;
          localparam bit IOTA_HERE = (i == 0) && (r == 0) && (x == 0) &&
                                     (j == ((SHARES > 1) ? 1 : 0));
          logic term;
          if (i == j) begin : g_inner
            if ((LESS_RAND != 0) && (i + 2 >= SHARES)) begin : g_omit
              assign term = ~InputxDI[B1] & InputxDI[B2];
            end else begin : g_full
              assign term = InputxDI[B0] ^ (~InputxDI[B1] & InputxDI[B2]);
            end
          end else begin : g_cross
            localparam int unsigned LO = (i < j) ? i : j;
            localparam int unsigned HI = (i < j) ? j : i;
            localparam int unsigned P  = LO + HI * (HI - 1) / 2;
            localparam int unsigned ZB = (P * ROWS + r) * 5 + x;
            logic fresh;
            // Last pair reuses each side's own S[x]; its inner terms drop S[x] to compensate.
            if ((LESS_RAND != 0) && (P == LAST_PAIR)) begin : g_reuse
              assign fresh = InputxDI[B0];
            end else begin : g_z
              assign fresh = ZxDI[ZB];
            end
            assign term = (InputxDI[B1] & InputxDI[JB2]) ^ fresh;
          end
          if (IOTA_HERE) begin : g_iota
            assign dom_d[D] = term ^ rc_bit;
          end else begin : g_plain
            assign dom_d[D] = term;
          end
        end
      end
    end
  end

  // Stage-2 compression: share i is the XOR of its SHARES stage-1 terms.
  for (genvar i = 0; i < SHARES; i++) begin : g_ci
    for (genvar r = 0; r < ROWS; r++) begin : g_cr
      for (genvar x = 0; x < 5; x++) begin : g_cx
        logic [SHARES-1:0] col;
        for (genvar j = 0; j < SHARES; j++) begin : g_cj
          assign col[j] = dom_q[((i * SHARES + j) * ROWS + r) * 5 + x];
        end
        assign out_d[(i * ROWS + r) * 5 + x] = ^col;
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin : p_regs
    if (!RstxRBI) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      inflight_q <= '0;
      dom_q      <= '0;
      out_q      <= '0;
    end else begin
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      inflight_q <= inflight_d;
      if (load1) dom_q <= dom_d;
      if (load2) out_q <= out_d;
    end
  end

  assign OutValidxSO = v2_q;
  assign OutputxDO   = out_q;
  assign InFlightxDO = inflight_q;

endmodule
